// File: rtl/pattern_detector_pkg.sv
// Shared definitions for the pattern detector: default pattern, history-fill width
// helper and the IDLE/ARMED state encoding.
package pattern_detector_pkg;

    localparam int          DEF_PAT_W   = 4;
    localparam logic [15:0] DEF_PATTERN = 16'b1011;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } det_state_e;

    // Width needed to hold a fill count of 0..pat_w inclusive.
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky all-ones flag and a synchronous clear that
// takes priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else begin
            if (inc && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
            sat_d = sat_q | (&cnt_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector with overlap control. Match counting is built only when
// PATTERN_DETECTOR_CNT_EN is defined; otherwise match_cnt/cnt_sat read as zero.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int             PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN[PAT_W-1:0],
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din_valid,
    input  logic                       din,
    input  logic                       clr_cnt,
    output logic                       match,
    output logic [fill_w(PAT_W)-1:0]   fill,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       cnt_sat
);

    localparam int               FILL_W = fill_w(PAT_W);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
    logic              match_q, match_d;
    det_state_e        state;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path infers a latch.
        state      = (fill_q == FULL) ? ARMED : IDLE;
        hist_shift = {hist_q[PAT_W-2:0], din};
        fill_inc   = (state == ARMED) ? fill_q : fill_q + 1'b1;
        hist_d     = hist_q;
        fill_d     = fill_q;
        match_d    = 1'b0;
        if (din_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if ((fill_inc == FULL) && (hist_shift == PATTERN)) begin
                match_d = 1'b1;
                // Non-overlapping mode drops back to IDLE and refills from scratch.
                if (!OVERLAP) begin
                    hist_d = '0;
                    fill_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;
    assign fill  = fill_q;

`ifdef PATTERN_DETECTOR_CNT_EN
    // Counter is fed match_d so it updates on the same edge that raises match.
    sat_counter #(
        .W(CNT_W)
    ) u_sat_counter (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (match_d),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign match_cnt      = '0;
    assign cnt_sat        = 1'b0;
`endif

endmodule
